ecc_channel_injector: RTL and testbench

- Channel-model stage between Encoder and Decoder in the ECC test path.
- Buffers encoded codewords in a small FIFO and optionally flips 0, 1 or 2 codeword bits per word, under a programmable mode.
- Lets the Decoder's single-error-correct / double-error-detect paths be exercised in-system.
- Keeps saturating statistics counters.

---
 rtl/ecc_pkg.sv | 29 ++
 rtl/ecc_lfsr16.sv | 25 ++
 rtl/ecc_channel_injector.sv | 131 +++++++++++++
 tb/tb_ecc_channel_injector.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared ECC definitions for the Encoder, channel injector and Decoder.
// Holds injection mode encodings, LFSR taps and the legal codeword widths.
package ecc_pkg;

    typedef enum logic [1:0] {
        INJ_NONE   = 2'd0,
        INJ_SINGLE = 2'd1,
        INJ_DOUBLE = 2'd2,
        INJ_RANDOM = 2'd3
    } inj_mode_t;

    // Fibonacci taps 16,14,13,11 expressed as state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int NUM_LEGAL_WIDTHS = 3;
    localparam int LEGAL_WIDTHS [NUM_LEGAL_WIDTHS] = '{8, 16, 32};

    function automatic logic is_legal_width(input int width);
        logic legal;
        legal = 1'b0;
        for (int i = 0; i < NUM_LEGAL_WIDTHS; i++) begin
            if (LEGAL_WIDTHS[i] == width) begin
                legal = 1'b1;
            end
        end
        return legal;
    endfunction

endpackage

// File: rtl/ecc_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step whenever step is high.
module ecc_lfsr16
    import ecc_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] state
);

    logic feedback;

    assign feedback = ^(state & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (step) begin
            state <= {state[14:0], feedback};
        end
    end

endmodule

// File: rtl/ecc_channel_injector.sv
// Channel model between Encoder and Decoder: buffers codewords in a FIFO,
// flips 0-2 bits per word at accept time and keeps saturating statistics.
module ecc_channel_injector
    import ecc_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter int          POS_W      = $clog2(DATA_WIDTH),
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  in_ready,
    input  logic [1:0]            inj_mode,
    input  logic [POS_W-1:0]      inj_pos0,
    input  logic [POS_W-1:0]      inj_pos1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  out_ready,
    output logic [15:0]           word_count,
    output logic [15:0]           flip_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    inj_mode_t             mode;
    logic [DATA_WIDTH-1:0] mask;
    logic [POS_W-1:0]      second_pos;
    logic [1:0]            mask_ones;
    logic                  lfsr_step;
    logic [15:0]           lfsr_state;
    logic [16:0]           flip_sum;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign in_ready = !full;
    assign valid    = !empty;
    assign push     = valid_in && !full;
    assign pop      = !empty && out_ready;
    assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

    ecc_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // A repeated DOUBLE position moves to its neighbour so two bits always flip.
    always_comb begin
        mask       = '0;
        lfsr_step  = 1'b0;
        mode       = inj_mode_t'(inj_mode);
        second_pos = inj_pos1;
        if (inj_pos1 == inj_pos0) begin
            second_pos = inj_pos0 + POS_W'(1);
        end
        case (mode)
            INJ_NONE: begin
                mask = '0;
            end
            INJ_SINGLE: begin
                mask[inj_pos0] = 1'b1;
            end
            INJ_DOUBLE: begin
                mask[inj_pos0]   = 1'b1;
                mask[second_pos] = 1'b1;
            end
            INJ_RANDOM: begin
                mask[lfsr_state[POS_W-1:0]] = 1'b1;
                lfsr_step                   = push;
            end
            default: begin
                mask = '0;
            end
        endcase
    end

    assign mask_ones = 2'($countones(mask));
    assign flip_sum  = {1'b0, flip_count} + {15'b0, mask_ones};

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[AW-1:0]] <= data_in ^ mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
            flip_count <= '0;
        end else begin
            if (pop && (word_count != 16'hFFFF)) begin
                word_count <= word_count + 16'd1;
            end
            if (push) begin
                flip_count <= flip_sum[16] ? 16'hFFFF : flip_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_ecc_channel_injector.sv
// Directed self-checking bench for ecc_channel_injector with hand-computed vectors.
module tb_ecc_channel_injector;
    import ecc_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic        valid_in;
    logic        in_ready;
    logic [1:0]  inj_mode;
    logic [4:0]  inj_pos0;
    logic [4:0]  inj_pos1;
    logic [31:0] data_out;
    logic        valid;
    logic        out_ready;
    logic [15:0] word_count;
    logic [15:0] flip_count;

    int check_count;
    int error_count;
    int exp_words;
    int exp_flips;

    ecc_channel_injector #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4),
        .POS_W      (5),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .in_ready   (in_ready),
        .inj_mode   (inj_mode),
        .inj_pos0   (inj_pos0),
        .inj_pos1   (inj_pos1),
        .data_out   (data_out),
        .valid      (valid),
        .out_ready  (out_ready),
        .word_count (word_count),
        .flip_count (flip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one word and holds it until accepted; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic [31:0] d, input logic [1:0] m,
                                 input logic [4:0] p0, input logic [4:0] p1);
        int waited;
        data_in  = d;
        inj_mode = m;
        inj_pos0 = p0;
        inj_pos1 = p1;
        valid_in = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 50) begin
            checkOutput("push_ready", {31'b0, in_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_words"}, {16'b0, word_count}, exp_words[31:0]);
        checkOutput({tag, "_flips"}, {16'b0, flip_count}, exp_flips[31:0]);
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        exp_words   = 0;
        exp_flips   = 0;
        rst         = 1'b1;
        data_in     = '0;
        valid_in    = 1'b0;
        inj_mode    = INJ_NONE;
        inj_pos0    = '0;
        inj_pos1    = '0;
        out_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_valid", {31'b0, valid}, 32'd0);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset_data_out", data_out, 32'h0);
        checkCounters("reset");

        applyStimulus(32'h1234_5678, INJ_NONE, 5'd0, 5'd0);
        checkOutput("none_data", data_out, 32'h1234_5678);
        checkOutput("none_valid", {31'b0, valid}, 32'd1);
        @(posedge clk);
        #1;
        exp_words = 1;
        checkOutput("none_popped", {31'b0, valid}, 32'd0);
        checkCounters("none");

        applyStimulus(32'h0000_0000, INJ_SINGLE, 5'd5, 5'd0);
        checkOutput("single_data", data_out, 32'h0000_0020);
        exp_flips = 1;
        checkOutput("single_flips", {16'b0, flip_count}, exp_flips[31:0]);
        @(posedge clk);
        #1;
        exp_words = 2;

        applyStimulus(32'hFFFF_FFFF, INJ_DOUBLE, 5'd31, 5'd31);
        checkOutput("double_same_data", data_out, 32'h7FFF_FFFE);
        applyStimulus(32'h0000_0000, INJ_DOUBLE, 5'd0, 5'd4);
        checkOutput("double_distinct_data", data_out, 32'h0000_0011);
        @(posedge clk);
        #1;
        exp_words = 4;
        exp_flips = 5;
        checkCounters("double");

        out_ready = 1'b0;
        applyStimulus(32'hA000_0000, INJ_NONE, 5'd0, 5'd0);
        applyStimulus(32'hA000_0001, INJ_NONE, 5'd0, 5'd0);
        applyStimulus(32'hA000_0002, INJ_NONE, 5'd0, 5'd0);
        applyStimulus(32'hA000_0003, INJ_NONE, 5'd0, 5'd0);
        checkOutput("full_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("full_head", data_out, 32'hA000_0000);
        data_in  = 32'hA000_0004;
        valid_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("held_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("held_head", data_out, 32'hA000_0000);
        checkOutput("held_valid", {31'b0, valid}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("drain_1", data_out, 32'hA000_0001);
        checkOutput("drain_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        checkOutput("drain_2", data_out, 32'hA000_0002);
        @(posedge clk);
        #1;
        checkOutput("drain_3", data_out, 32'hA000_0003);
        @(posedge clk);
        #1;
        checkOutput("drain_4", data_out, 32'hA000_0004);
        @(posedge clk);
        #1;
        checkOutput("drain_empty", {31'b0, valid}, 32'd0);
        exp_words = 9;
        checkCounters("drain");

        // LFSR states from seed: ACE1, 59C3, B387 -> positions 1, 3, 7.
        applyStimulus(32'h0000_0000, INJ_RANDOM, 5'd0, 5'd0);
        checkOutput("random_0", data_out, 32'h0000_0002);
        checkOutput("random_0_ones", $countones(data_out ^ 32'h0000_0000), 32'd1);
        applyStimulus(32'h0F0F_0F0F, INJ_RANDOM, 5'd0, 5'd0);
        checkOutput("random_1", data_out, 32'h0F0F_0F07);
        checkOutput("random_1_ones", $countones(data_out ^ 32'h0F0F_0F0F), 32'd1);
        applyStimulus(32'hFFFF_0000, INJ_RANDOM, 5'd0, 5'd0);
        checkOutput("random_2", data_out, 32'hFFFF_0080);
        checkOutput("random_2_ones", $countones(data_out ^ 32'hFFFF_0000), 32'd1);
        @(posedge clk);
        #1;
        exp_words = 12;
        exp_flips = 8;
        checkCounters("random");

        out_ready = 1'b0;
        applyStimulus(32'h1111_1111, INJ_SINGLE, 5'd2, 5'd0);
        applyStimulus(32'h2222_2222, INJ_NONE, 5'd0, 5'd0);
        applyStimulus(32'h3333_3333, INJ_NONE, 5'd0, 5'd0);
        checkOutput("prereset_valid", {31'b0, valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_words = 0;
        exp_flips = 0;
        checkOutput("midreset_valid", {31'b0, valid}, 32'd0);
        checkOutput("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("midreset_data_out", data_out, 32'h0);
        checkCounters("midreset");

        out_ready = 1'b1;
        applyStimulus(32'h0000_0000, INJ_RANDOM, 5'd0, 5'd0);
        checkOutput("postreset_random", data_out, 32'h0000_0002);
        @(posedge clk);
        #1;
        exp_words = 1;
        exp_flips = 1;
        checkCounters("postreset");
        checkOutput("postreset_empty", {31'b0, valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got 0 expected 1");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
